// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared types and constants for the instruction fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   localparam int AW_DEF  = 32;
   localparam int DW_DEF  = 32;
   localparam int ENTRY_W = AW_DEF + DW_DEF;

   localparam logic [7:0] TIMEOUT_MAX = 8'd255;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_if
// Brief    : PC stream, memory read and decode handshakes of the fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_fetch_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic [AW-1:0] pc_in;
   logic          pc_valid;
   logic          pc_ready;
   logic          redirect;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_ack;
   logic [DW-1:0] mem_rdata;
   logic          instr_valid;
   logic          instr_ready;
   logic [DW-1:0] instr_out;
   logic [AW-1:0] instr_pc;
   logic          fetch_err;

   // slave is the fetch unit; master is the surrounding pipeline and memory
   modport slave (
      input  pc_in, pc_valid, redirect, mem_ack, mem_rdata, instr_ready,
      output pc_ready, mem_req, mem_addr, instr_valid, instr_out, instr_pc, fetch_err
   );

   modport master (
      output pc_in, pc_valid, redirect, mem_ack, mem_rdata, instr_ready,
      input  pc_ready, mem_req, mem_addr, instr_valid, instr_out, instr_pc, fetch_err
   );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Small synchronous FIFO of {pc, instruction} entries with flush.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = ENTRY_W,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  wire logic          clock,
   input  wire logic          reset,
   input  wire logic          push,
   input  wire logic          pop,
   input  wire logic          flush,
   input  wire logic [W-1:0]  din,
   output      logic [CW-1:0] count,
   output      logic [W-1:0]  head
);

   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [W-1:0]  store [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != FULL) || do_pop);
   assign head    = store[rd_ptr];

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            store[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            store[wr_ptr] <= din;
            wr_ptr        <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         // power-of-two depth lets the pointers wrap on their own
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : Fetches PC words over req/ack and buffers {pc, instr} for decode.
//            Define FETCH_TIMEOUT_EN for the stuck-request watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = AW_DEF,
   parameter int DW    = DW_DEF
) (
   input  wire logic     clock,
   input  wire logic     reset,
   instr_fetch_if.slave  bus
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   fetch_state_t     state;
   logic             mem_req;
   logic [AW-1:0]    mem_addr;
   logic [CW-1:0]    count;
   logic [AW+DW-1:0] head;
   logic             pc_ready;
   logic             accept;
   logic             push;
   logic             pop;

   // a PC is taken only with a free slot, so the returning ack can always push
   assign pc_ready = !reset && !bus.redirect && (state == IDLE) && (count < FULL);
   assign accept   = bus.pc_valid && pc_ready;
   assign push     = (state == WAIT) && bus.mem_ack && !bus.redirect;
   assign pop      = (count != '0) && bus.instr_ready;

   fetch_fifo #(
      .DEPTH (DEPTH),
      .W     (AW + DW)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (bus.redirect),
      .din   ({mem_addr, bus.mem_rdata}),
      .count (count),
      .head  (head)
   );

   assign bus.pc_ready    = pc_ready;
   assign bus.mem_req     = mem_req;
   assign bus.mem_addr    = mem_addr;
   assign bus.instr_valid = (count != '0);
   assign bus.instr_pc    = head[AW+DW-1:DW];
   assign bus.instr_out   = head[DW-1:0];

`ifdef FETCH_TIMEOUT_EN
   logic [7:0] timer;
   logic       fetch_err;
   assign bus.fetch_err = fetch_err;
`else
   assign bus.fetch_err = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         mem_req  <= 1'b0;
         mem_addr <= '0;
`ifdef FETCH_TIMEOUT_EN
         timer     <= 8'd0;
         fetch_err <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  mem_addr <= bus.pc_in;
                  mem_req  <= 1'b1;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               if (bus.mem_ack) begin
                  mem_req <= 1'b0;
                  state   <= IDLE;
               end else if (bus.redirect) begin
                  state <= DROP;
               end
            end
            DROP: begin
               // the request stays up until memory answers; the data is thrown away
               if (bus.mem_ack) begin
                  mem_req <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: begin
               mem_req <= 1'b0;
               state   <= IDLE;
            end
         endcase
`ifdef FETCH_TIMEOUT_EN
         if (state == IDLE || bus.mem_ack) begin
            timer <= 8'd0;
         end else if (timer == TIMEOUT_MAX - 8'd1) begin
            timer     <= 8'd0;
            fetch_err <= 1'b1;
            mem_req   <= 1'b0;
            state     <= IDLE;
         end else begin
            timer <= timer + 8'd1;
         end
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Directed and random checks of instr_fetch against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

   localparam int DEPTH = 4;

   logic clk;
   logic reset;

   instr_fetch_if #(.AW(32), .DW(32)) bus ();

   instr_fetch #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
      .clock (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_assert = 0;
   int n_fail   = 0;

   // reference model: buffered entries plus the single outstanding fetch
   logic [63:0] q[$];
   logic        pending   = 1'b0;
   logic        live      = 1'b0;
   logic [31:0] last_addr = '0;
   logic        exp_err   = 1'b0;
   logic        last_acc  = 1'b0;
   int          n_acc     = 0;
   int          n_pop     = 0;

   // memory responder settings
   int   mem_wait = 0;
   int   wcnt     = 0;
   logic ack_en   = 1'b1;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return 32'h1000 + a;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle(input logic pv, input logic [31:0] pc, input logic rd,
                        input logic ir, input logic rs = 1'b0);
      logic exp_ready;
      logic ack;
      @(negedge clk);
      reset           = rs;
      bus.pc_valid    = pv;
      bus.pc_in       = pc;
      bus.redirect    = rd;
      bus.instr_ready = ir;
      ack = 1'b0;
      if (bus.mem_req && ack_en && wcnt >= mem_wait) begin
         ack  = 1'b1;
         wcnt = 0;
         bus.mem_rdata = mem_fn(bus.mem_addr);
      end else begin
         wcnt = bus.mem_req ? wcnt + 1 : 0;
         bus.mem_rdata = $urandom;
      end
      bus.mem_ack = ack;
      #1;
      exp_ready = !rs && !rd && !pending && (q.size() < DEPTH);
      chk("pc_ready", bus.pc_ready, exp_ready);
      chk("mem_req", bus.mem_req, pending);
      chk("mem_addr", bus.mem_addr, last_addr);
      chk("fetch_err", bus.fetch_err, exp_err);
      chk("instr_valid", bus.instr_valid, q.size() != 0);
      if (q.size() != 0) begin
         chk("instr_pc", bus.instr_pc, q[0][63:32]);
         chk("instr_out", bus.instr_out, q[0][31:0]);
      end
      last_acc = pv && exp_ready;
      if (rs) begin
         q.delete();
         pending   = 1'b0;
         last_addr = '0;
         exp_err   = 1'b0;
         wcnt      = 0;
      end else if (rd) begin
         q.delete();
         if (pending && ack) pending = 1'b0;
         else if (pending)   live    = 1'b0;
      end else begin
         if (q.size() != 0 && ir) begin
            void'(q.pop_front());
            n_pop++;
         end
         if (pending && ack) begin
            if (live) q.push_back({last_addr, mem_fn(last_addr)});
            pending = 1'b0;
         end
         if (last_acc) begin
            pending   = 1'b1;
            live      = 1'b1;
            last_addr = pc;
            n_acc++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [31:0] pc, input logic ir);
      int n = 0;
      do begin
         cycle(1'b1, pc, 1'b0, ir);
         n++;
      end while (!last_acc && n < 50);
      chk("offer_accepted", last_acc, 1'b1);
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || pending) && n < 100) begin
         cycle(1'b0, '0, 1'b0, 1'b1);
         n++;
      end
      chk("drain_done", (q.size() == 0) && !pending, 1'b1);
   endtask

   initial begin
      int a0;
      int p0;
      int nxt;
      reset           = 1'b1;
      bus.pc_valid    = 1'b0;
      bus.pc_in       = '0;
      bus.redirect    = 1'b0;
      bus.instr_ready = 1'b0;
      bus.mem_ack     = 1'b0;
      bus.mem_rdata   = '0;

      // reset state
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk("rst_instr_out", bus.instr_out, '0);
      chk("rst_instr_pc", bus.instr_pc, '0);
      chk("rst_mem_req", bus.mem_req, 1'b0);
      chk("rst_mem_addr", bus.mem_addr, '0);
      cycle(1'b0, '0, 1'b0, 1'b0);

      // zero-wait stream with two-cycle latency
      mem_wait = 0;
      offer(32'd0, 1'b0);
      chk("lat_req", bus.mem_req, 1'b1);
      cycle(1'b0, '0, 1'b0, 1'b0);
      chk("lat_valid", bus.instr_valid, 1'b1);
      chk("lat_out", bus.instr_out, 32'h1000);
      for (int i = 1; i < 4; i++) offer(i, 1'b1);
      drain();

      // backpressure to full
      a0 = n_acc;
      p0 = n_pop;
      nxt = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, nxt, 1'b0, 1'b0);
         if (last_acc && nxt < 5) nxt++;
      end
      chk("full_accepts", n_acc - a0, DEPTH);
      chk("full_pc_ready", bus.pc_ready, 1'b0);
      while (nxt < 6) begin
         offer(nxt, 1'b1);
         nxt++;
      end
      drain();
      chk("full_delivered", n_pop - p0, 6);

      // redirect in the first wait cycle
      mem_wait = 3;
      offer(32'h20, 1'b1);
      cycle(1'b1, 32'h99, 1'b1, 1'b1);
      chk("drop_req_held", bus.mem_req, 1'b1);
      drain();
      chk("drop_empty", bus.instr_valid, 1'b0);
      offer(32'h40, 1'b1);
      drain();

      // redirect, ack and pop together
      mem_wait = 0;
      offer(32'h50, 1'b0);
      offer(32'h51, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0);
      offer(32'h52, 1'b0);
      chk("rap_buffered", q.size(), 2);
      cycle(1'b0, '0, 1'b1, 1'b1);
      chk("rap_valid", bus.instr_valid, 1'b0);
      chk("rap_req", bus.mem_req, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b1);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         if (!pending) mem_wait = $urandom_range(0, 3);
         cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 15) == 0,
               $urandom_range(0, 2) != 0);
      end
      drain();

      // reset while waiting on memory
      mem_wait = 3;
      offer(32'h30, 1'b1);
      cycle(1'b0, '0, 1'b0, 1'b1);
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
      chk("mid_rst_req", bus.mem_req, 1'b0);
      chk("mid_rst_valid", bus.instr_valid, 1'b0);
      chk("mid_rst_addr", bus.mem_addr, '0);
      cycle(1'b0, '0, 1'b0, 1'b1);

`ifdef FETCH_TIMEOUT_EN
      begin
         int k;
         ack_en = 1'b0;
         offer(32'h77, 1'b1);
         bus.pc_valid = 1'b0;
         k = 0;
         while (k < 300) begin
            @(posedge clk);
            #1;
            k++;
            if (bus.fetch_err) break;
         end
         chk("tmo_cycles", k, 255);
         chk("tmo_req", bus.mem_req, 1'b0);
         chk("tmo_ready", bus.pc_ready, 1'b1);
         repeat (5) @(posedge clk);
         #1;
         chk("tmo_sticky", bus.fetch_err, 1'b1);
         pending = 1'b0;
         exp_err = 1'b1;
         ack_en  = 1'b1;
         cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
         cycle(1'b0, '0, 1'b0, 1'b1);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Consumer end of the PC sequencer. Takes the word-addressed PC stream (PC advances +1 per instruction), fetches each word from instruction memory over a req/ack handshake, and buffers {pc, instruction} pairs in a small FIFO for decode.
- Sits between the PC sequencer and the decode stage.
- A redirect (taken jump/branch) flushes buffered and in-flight fetches.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- AW, 32, PC / memory word-address width.
- DW, 32, instruction width.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- pc_in  in  AW  word address to fetch.
- pc_valid  in  1  pc_in is valid.
- pc_ready  out  1  PC accepted when pc_valid && pc_ready.
- redirect  in  1  flush: discard all buffered and in-flight fetches.
- mem_req  out  1  memory read request, held until mem_ack.
- mem_addr  out  AW  read address, stable while mem_req is high.
- mem_ack  in  1  read data valid this cycle.
- mem_rdata  in  DW  read data.
- instr_valid  out  1  FIFO head is valid.
- instr_ready  in  1  decode consumes the head when instr_valid && instr_ready.
- instr_out  out  DW  head instruction.
- instr_pc  out  AW  PC of the head instruction.
- fetch_err  out  1  only with FETCH_TIMEOUT_EN; otherwise tied to 0.

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset` is synchronous and active-high.
- Reset values:
  - state IDLE; count 0; FIFO pointers 0.
  - mem_req 0, mem_addr 0.
  - instr_valid 0, instr_out 0, instr_pc 0, fetch_err 0.
  - pc_ready 0 while reset is high.
- Reset mid-transaction: abandons any outstanding request. Memory must tolerate a dropped request.
- FSM states and transitions:
  - IDLE: pc_ready = !redirect && (count < DEPTH). On accept: mem_addr <= pc_in, mem_req <= 1, go to WAIT.
  - WAIT: mem_req held at 1, pc_ready = 0.
    - On mem_ack && !redirect: push {mem_addr, mem_rdata}, mem_req <= 0, go to IDLE.
    - On redirect without mem_ack: go to DROP.
    - On redirect && mem_ack in the same cycle: discard the data, go to IDLE.
  - DROP: mem_req stays 1 (a request is never withdrawn), pc_ready = 0. On mem_ack: discard, mem_req <= 0, go to IDLE.
- Slot reservation: a PC is accepted only if a FIFO slot is free, so a returning ack can always push. There is no overflow path.
- Latency: PC accepted at edge N → mem_req high in cycle N+1. With a zero-wait ack in N+1, instr_valid is high in N+2. Minimum 2 cycles PC→instr. Throughput is one instruction per 2 cycles at zero wait; one fetch is in flight at a time.
- FIFO:
  - instr_valid = (count != 0). instr_out and instr_pc are driven from the head and held stable while stalled.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
  - Full: count == DEPTH forces pc_ready = 0.
  - Empty: instr_valid = 0, instr_ready is ignored.
- Redirect:
  - Takes priority over push, pop and accept in the same cycle.
  - FIFO is cleared (count 0, pointers 0), so instr_valid = 0 in the next cycle.
  - pc_valid is ignored during the redirect cycle.
- Width: mem_addr equals the PC with no shift (word addressing).

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- With the macro:
  - An 8-bit counter runs in WAIT and DROP and clears on mem_ack.
  - When it reaches 255, fetch_err is set (sticky until reset), mem_req drops, the FSM returns to IDLE, and nothing is pushed.
  - A late ack arriving in IDLE is ignored.
- Without the macro: no counter; fetch_err is a constant 0.

Decomposition:
- Package fetch_pkg:
  - FSM state encoding: IDLE=2'd0, WAIT=2'd1, DROP=2'd2.
  - Default widths.
  - Entry width constant ENTRY_W = AW+DW.
  - TIMEOUT_MAX = 8'd255.
- One sub-module, fetch_fifo:
  - Parameterised DEPTH/width.
  - Ports: push, pop, flush, count, head data.
  - Synchronous flush that takes priority over push/pop.
- The FSM and handshake logic live in instr_fetch.

Test Plan:
- Zero-wait stream:
  - Stimulus: PCs 0,1,2,3 offered back-to-back, mem_ack in the same cycle as mem_req, mem_rdata = 0x1000+addr, instr_ready = 1.
  - Response: the instruction for PC 0 appears 2 cycles after acceptance; outputs are (0,0x1000),(1,0x1001),(2,0x1002),(3,0x1003) in order.
- Backpressure to full:
  - Stimulus: instr_ready = 0, DEPTH = 4, PCs 0..5 offered.
  - Response: exactly 4 PCs accepted and pc_ready stays 0. After instr_ready = 1, PCs 4 and 5 are accepted; there is no loss or duplication.
- Redirect during wait:
  - Stimulus: PC 0x20 issued, mem_ack delayed 3 cycles, redirect pulsed in the first wait cycle.
  - Response: state DROP, mem_req held until ack, data discarded, FIFO empty, then PC 0x40 fetches normally.
- Redirect with ack and pop in the same cycle:
  - Stimulus: 2 entries buffered, redirect, mem_ack and instr_ready all high together.
  - Response: next cycle count = 0, instr_valid = 0, no push.
- Synchronous reset mid-WAIT:
  - Stimulus: reset high for 1 cycle.
  - Response: mem_req = 0, instr_valid = 0, pc_ready = 0 during reset and 1 afterwards; mem_addr = 0.
- FETCH_TIMEOUT_EN:
  - Stimulus: mem_ack never asserted.
  - Response: fetch_err = 1 exactly 255 cycles after mem_req rises, mem_req = 0, FSM in IDLE; fetch_err stays high until reset.
